// File: rtl/signdiv32_if.sv
// Request/result bundle for the signdiv32 iterative signed divider.
// The requester drives start/a/b; the divider answers with busy/done/q/r/div_zero.
interface signdiv32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_zero
    );
endinterface

// File: rtl/signdiv32.sv
// Iterative signed divider: restoring unsigned core on operand magnitudes, one
// quotient bit per cycle, then sign fix-up. Quotient truncates toward zero.
module signdiv32 #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    signdiv32_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic             r_sa;
    logic             r_sb;
    logic [CW-1:0]    r_cnt;

    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;

    logic             w_accept;
    logic             w_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_qbit;

    assign w_accept = (r_state == S_IDLE) && bus.start && (bus.b != '0);
    assign w_zero   = (r_state == S_IDLE) && bus.start && (bus.b == '0);

    // Magnitudes as unsigned: -0x8000_0000 wraps back to 0x8000_0000, which is exact.
    assign w_abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_dvs};
    assign w_qbit  = ~w_diff[WIDTH+1];

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dvd <= w_abs_a;
                        r_dvs <= w_abs_b;
                        r_sa  <= bus.a[WIDTH-1];
                        r_sb  <= bus.b[WIDTH-1];
                        r_rem <= '0;
                        r_cnt <= CW'(WIDTH - 1);
                    end else if (w_zero) begin
                        r_q    <= '1;
                        r_r    <= bus.a;
                        r_dz   <= 1'b1;
                        r_done <= 1'b1;
                    end
                end
                S_CALC: begin
                    // Dividend register doubles as the quotient shift register.
                    r_rem <= w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_q    <= (r_sa ^ r_sb) ? -r_dvd : r_dvd;
                    r_r    <= r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                    r_dz   <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.q        = r_q;
    assign bus.r        = r_r;
    assign bus.div_zero = r_dz;
endmodule

// File: tb/tb_signdiv32.sv
// Self-checking bench for signdiv32: directed corner cases, ignored-start,
// mid-operation reset, and a long back-to-back random run against a signed model.
module tb_signdiv32;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    signdiv32_if #(.WIDTH(32)) bus ();

    signdiv32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed division done with wide integers; SV '/' truncates toward
    // zero and '%' takes the dividend's sign, and the 64-bit range covers -2^31/-1.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            q  = lq[31:0];
            r  = lr[31:0];
            dz = 1'b0;
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = 32'($urandom_range(0, 40)) - 32'd20;
            1: v = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            2: v = 32'($urandom_range(0, 65535));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // One isolated request; optional second start pulse at cycle poke_at while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input logic [31:0] pa, input logic [31:0] pb);
        logic [31:0] eq, er;
        logic        edz;
        int          lat;
        int          bcnt;
        model(a, b, eq, er, edz);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat  = 0;
        bcnt = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == poke_at) begin
                bus.start = 1'b1;
                bus.a     = pa;
                bus.b     = pb;
            end else if (lat == poke_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.busy) bcnt++;
            if (bus.done) break;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("latency", 32'(lat), edz ? 32'd1 : 32'd34);
        check("busy_cycles", 32'(bcnt), edz ? 32'd0 : 32'd33);
        check("q", bus.q, eq);
        check("r", bus.r, er);
        check("div_zero", 32'(bus.div_zero), 32'(edz));
        @(negedge clk);
        bus.start = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("q_hold", bus.q, eq);
        check("r_hold", bus.r, er);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          n;
        int          dcnt;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", bus.q, 32'd0);
        check("rst_r", bus.r, 32'd0);
        check("rst_dz", 32'(bus.div_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(-32'sd12, 32'sd4, -1, '0, '0);
        check("m12_div_4_q", bus.q, 32'hFFFF_FFFD);
        check("m12_div_4_r", bus.r, 32'h0000_0000);

        run_op(-32'sd3, -32'sd4, -1, '0, '0);
        check("m3_div_m4_r", bus.r, 32'hFFFF_FFFD);
        run_op(32'sd7, -32'sd2, -1, '0, '0);
        check("7_div_m2_r", bus.r, 32'd1);
        run_op(-32'sd7, 32'sd2, -1, '0, '0);
        check("m7_div_2_r", bus.r, 32'hFFFF_FFFF);

        run_op(32'd100, 32'd0, -1, '0, '0);
        check("div0_q", bus.q, 32'hFFFF_FFFF);
        check("div0_r", bus.r, 32'd100);
        run_op(32'd9, 32'd3, -1, '0, '0);
        check("after_div0_flag", 32'(bus.div_zero), 32'd0);
        check("9_div_3_q", bus.q, 32'd3);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, '0, '0);
        check("min_div_m1_q", bus.q, 32'h8000_0000);
        run_op(32'h8000_0000, 32'd1, -1, '0, '0);
        check("min_div_1_q", bus.q, 32'h8000_0000);
        run_op(32'd5, 32'h8000_0000, -1, '0, '0);

        run_op(32'd50, 32'd7, 10, 32'd1000, 32'd3);
        check("ignored_start_q", bus.q, 32'd7);
        check("ignored_start_r", bus.r, 32'd1);

        // Mid-operation reset: outputs currently hold 7/1 and must clear at once.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd123456;
        bus.b     = 32'd789;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_q", bus.q, 32'd0);
        check("midrst_r", bus.r, 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_dz", 32'(bus.div_zero), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("no_done_after_rst", 32'(dcnt), 32'd0);
        check("idle_after_rst", 32'(bus.busy), 32'd0);

        // Back-to-back random run with start held high throughout.
        ra = rand_operand();
        do rb = rand_operand(); while (rb == 32'd0);
        @(negedge clk);
        bus.a     = ra;
        bus.b     = rb;
        bus.start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            model(ra, rb, eq, er, edz);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.done && n < 40);
            check("bb_done_seen", 32'(bus.done), 32'd1);
            check("bb_latency", 32'(n), 32'd34);
            check("bb_q", bus.q, eq);
            check("bb_r", bus.r, er);
            check("bb_dz", 32'(bus.div_zero), 32'd0);
            check("bb_identity", bus.q * rb + bus.r, ra);
            check("bb_rem_bound", 32'(mag(bus.r) < mag(rb)), 32'd1);
            check("bb_rem_sign", 32'((bus.r == 32'd0) || (bus.r[31] == ra[31])), 32'd1);
            if (i < 999) begin
                ra = rand_operand();
                do rb = rand_operand(); while (rb == 32'd0);
                bus.a = ra;
                bus.b = rb;
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        check("bb_final_done_low", 32'(bus.done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
